// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
//   word_t   : common datapath word
//   wb_req_t : one queued MDU result (destination register + data)
//   wb_src_t : which requester owns the write port in a given cycle
package wb_port_arbiter_pkg;

  localparam int WB_WORD_W       = 64;
  localparam int WB_FIFO_DEPTH   = 2;
  localparam int WB_STARVE_LIMIT = 4;

  typedef logic [WB_WORD_W-1:0] word_t;

  typedef struct packed {
    logic [4:0] dst;
    word_t      data;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_PIPE = 1'b0,
    WB_SRC_MDU  = 1'b1
  } wb_src_t;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order FIFO of MDU results waiting for a free register-file write slot.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   push         : write push_data at the tail (ignored while full)
//   push_data    : result to enqueue
//   pop          : remove the head entry (ignored while empty)
//   head         : current head entry (meaningful only when count != 0)
//   count        : number of occupied entries
//   entry_valid  : per-slot occupancy, indexed by physical slot
//   entry_dst    : per-slot destination register, indexed by physical slot
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_req_t                    push_data,
  input  logic                       pop,
  output wb_req_t                    head,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DEPTH-1:0]           entry_valid,
  output logic [DEPTH-1:0][4:0]      entry_dst
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & (count != CNT_W'(DEPTH));
  assign do_pop  = pop  & (count != '0);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (do_push) begin
        wr_ptr              <= wr_ptr + 1'b1;
        entry_valid[wr_ptr] <= 1'b1;
      end
      // A simultaneous push can never hit the head slot: pushing requires
      // a non-full FIFO and popping a non-empty one, so the pointers differ.
      if (do_pop) begin
        rd_ptr              <= rd_ptr + 1'b1;
        entry_valid[rd_ptr] <= 1'b0;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by entry_valid/count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_dst[i] = mem[i].dst;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the in-order writeback
// stage and the MDU result FIFO. The pipeline has priority; an age counter
// forces an MDU drain (stalling the pipeline for one cycle) once the FIFO
// head has been passed over STARVE_LIMIT times.
//
// Handshakes: an MDU result transfers when mdu_valid & mdu_ready are both
// high at a clock edge; the MDU holds mdu_* stable while mdu_ready is low.
// The writeback stage holds its inputs while stall_pipe is high.
//
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   wb_valid/wb_regwrite/wb_dst/wb_data: writeback-stage write request
//   mdu_valid/mdu_ready/mdu_dst/mdu_data: MDU result handshake
//   rf_wen/rf_waddr/rf_wdata/rf_src    : register-file write port
//   stall_pipe                         : pipeline write denied this cycle
//   pending_mask                       : registers targeted by queued results
//   fifo_count                         : queued result count
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT,
  // Must match the package word width; results travel as word_t.
  parameter int WORD_W       = WB_WORD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic                     wb_regwrite,
  input  logic [4:0]               wb_dst,
  input  logic [WORD_W-1:0]        wb_data,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_dst,
  input  logic [WORD_W-1:0]        mdu_data,
  output logic                     rf_wen,
  output logic [4:0]               rf_waddr,
  output logic [WORD_W-1:0]        rf_wdata,
  output logic                     rf_src,
  output logic                     stall_pipe,
  output logic [31:0]              pending_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t              head;
  logic [CNT_W-1:0]     count;
  logic [DEPTH-1:0]     entry_valid;
  logic [DEPTH-1:0][4:0] entry_dst;
  logic [AGE_W-1:0]     age;

  logic    pipe_req;
  logic    mdu_req;
  logic    force_mdu;
  logic    grant_mdu;
  logic    grant_pipe;
  logic    do_push;
  wb_src_t src;

  // Requests are masked during reset so nothing is written or popped in the
  // reset cycle, even though the FIFO registers still hold old contents.
  assign pipe_req   = wb_valid & wb_regwrite & (wb_dst != 5'd0) & ~reset;
  assign mdu_req    = (count != '0) & ~reset;
  assign force_mdu  = pipe_req & mdu_req & (age == AGE_W'(STARVE_LIMIT));
  assign grant_mdu  = force_mdu | (~pipe_req & mdu_req);
  assign grant_pipe = pipe_req & ~force_mdu;
  assign stall_pipe = force_mdu;

  // Ready depends only on registered occupancy: a pop while full does not
  // open a slot until the next cycle.
  assign mdu_ready  = (count != CNT_W'(DEPTH)) & ~reset;
  // x0 results complete the handshake but are dropped.
  assign do_push    = mdu_valid & mdu_ready & (mdu_dst != 5'd0);

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (do_push),
    .push_data   ('{dst: mdu_dst, data: mdu_data}),
    .pop         (grant_mdu),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_dst   (entry_dst)
  );

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = '0;
    src      = WB_SRC_PIPE;
    if (grant_mdu) begin
      rf_wen   = 1'b1;
      rf_waddr = head.dst;
      rf_wdata = head.data;
      src      = WB_SRC_MDU;
    end else if (grant_pipe) begin
      rf_wen   = 1'b1;
      rf_waddr = wb_dst;
      rf_wdata = wb_data;
    end
  end

  assign rf_src = src;

  // Counts how many times the current head has been passed over. Any pop
  // (forced or idle) restarts it so the next head begins from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      age <= '0;
    end else if (grant_mdu || count == '0) begin
      age <= '0;
    end else if (grant_pipe && age != AGE_W'(STARVE_LIMIT)) begin
      age <= age + 1'b1;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        pending_mask[entry_dst[i]] = 1'b1;
      end
    end
    if (reset) begin
      pending_mask = '0;
    end
  end

  assign fifo_count = reset ? '0 : count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int DEPTH = WB_FIFO_DEPTH;
  localparam int LIMIT = WB_STARVE_LIMIT;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_regwrite;
  logic [4:0]  wb_dst;
  logic [63:0] wb_data;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_dst;
  logic [63:0] mdu_data;
  logic        rf_wen, rf_src, stall_pipe;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] pending_mask;
  logic [$clog2(DEPTH):0] fifo_count;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .wb_dst       (wb_dst),
    .wb_data      (wb_data),
    .mdu_valid    (mdu_valid),
    .mdu_ready    (mdu_ready),
    .mdu_dst      (mdu_dst),
    .mdu_data     (mdu_data),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_src       (rf_src),
    .stall_pipe   (stall_pipe),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count)
  );

  // ---------------- reference model ----------------
  // The queue holds the MDU results still owed to the register file; age is
  // how many times the current head has lost the port to the pipeline.
  typedef struct {
    logic [4:0]  dst;
    logic [63:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_age;
  bit   e_gm, e_gp, e_push, e_ready;
  logic [4:0] drain_q[$];

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs mid-cycle, and decide what the coming edge does.
  task automatic eval();
    bit pr, mr, fg;
    logic [31:0] e_mask;
    @(negedge clk);
    pr = wb_valid && wb_regwrite && wb_dst != 0 && !reset;
    mr = mq.size() > 0 && !reset;
    fg = pr && mr && m_age == LIMIT;
    e_gm = fg || (!pr && mr);
    e_gp = pr && !fg;
    e_ready = !reset && mq.size() < DEPTH;
    e_push = mdu_valid && e_ready && mdu_dst != 0;
    e_mask = '0;
    if (!reset) foreach (mq[i]) e_mask[mq[i].dst] = 1'b1;
    chk("rf_wen", rf_wen, e_gm || e_gp);
    chk("rf_waddr", rf_waddr, e_gm ? mq[0].dst : (e_gp ? wb_dst : 5'd0));
    chk("rf_wdata", rf_wdata, e_gm ? mq[0].data : (e_gp ? wb_data : 64'd0));
    chk("rf_src", rf_src, e_gm);
    chk("stall_pipe", stall_pipe, fg);
    chk("mdu_ready", mdu_ready, e_ready);
    chk("pending_mask", pending_mask, e_mask);
    chk("fifo_count", fifo_count, reset ? 0 : mq.size());
    if (rf_wen === 1'b1 && rf_src === 1'b1) drain_q.push_back(rf_waddr);
  endtask

  task automatic adv();
    bit was_empty;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_age = 0;
    end else begin
      was_empty = mq.size() == 0;
      if (e_gm) void'(mq.pop_front());
      if (e_push) mq.push_back('{dst: mdu_dst, data: mdu_data});
      if (e_gm || was_empty) m_age = 0;
      else if (e_gp && m_age < LIMIT) m_age++;
    end
    #1;
  endtask

  task automatic tick();
    eval();
    adv();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_wb(input logic v, input logic rw, input logic [4:0] d, input logic [63:0] x);
    wb_valid = v; wb_regwrite = rw; wb_dst = d; wb_data = x;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] d, input logic [63:0] x);
    mdu_valid = v; mdu_dst = d; mdu_data = x;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    m_age = 0;
    reset = 1'b1;
    set_wb(1, 1, 5'd3, 64'h33);
    set_mdu(1, 5'd9, 64'h99);

    // Reset with both requesters active.
    repeat (2) begin
      eval();
      chk("reset_wen", rf_wen, 0);
      chk("reset_stall", stall_pipe, 0);
      chk("reset_ready", mdu_ready, 0);
      chk("reset_count", fifo_count, 0);
      adv();
    end
    reset = 1'b0;
    set_wb(0, 0, 5'd0, 64'h0);
    set_mdu(0, 5'd0, 64'h0);
    eval();
    chk("post_reset_ready", mdu_ready, 1);
    adv();

    // Idle drain: no bypass in the push cycle, written the next cycle.
    set_mdu(1, 5'd5, 64'hAB);
    eval();
    chk("no_bypass_wen", rf_wen, 0);
    adv();
    set_mdu(0, 5'd0, 64'h0);
    eval();
    chk("drain_wen", rf_wen, 1);
    chk("drain_addr", rf_waddr, 5);
    chk("drain_data", rf_wdata, 64'hAB);
    chk("drain_src", rf_src, 1);
    chk("drain_mask", pending_mask, 32'h20);
    adv();
    eval();
    chk("drain_mask_clear", pending_mask, 0);
    adv();

    // Priority and starvation.
    set_mdu(1, 5'd7, 64'h77);
    tick();
    set_mdu(0, 5'd0, 64'h0);
    set_wb(1, 1, 5'd3, 64'h33);
    for (int i = 0; i < LIMIT; i++) begin
      eval();
      chk("starve_pipe_addr", rf_waddr, 3);
      chk("starve_pipe_src", rf_src, 0);
      adv();
    end
    eval();
    chk("forced_src", rf_src, 1);
    chk("forced_addr", rf_waddr, 7);
    chk("forced_stall", stall_pipe, 1);
    adv();
    eval();
    chk("after_force_addr", rf_waddr, 3);
    chk("after_force_stall", stall_pipe, 0);
    adv();

    // Full and backpressure with the pipeline still writing x3.
    drain_q.delete();
    set_mdu(1, 5'd1, 64'h11);
    tick();
    set_mdu(1, 5'd2, 64'h22);
    tick();
    set_mdu(1, 5'd4, 64'h44);
    eval();
    chk("full_count", fifo_count, 2);
    chk("full_ready", mdu_ready, 0);
    chk("full_mask", pending_mask, 32'h6);
    adv();
    for (int i = 0; i < 16; i++) begin
      eval();
      acc = mdu_valid && mdu_ready;
      adv();
      if (acc) set_mdu(0, 5'd0, 64'h0);
    end
    set_wb(0, 0, 5'd0, 64'h0);
    repeat (4) tick();
    chk("drain_n", drain_q.size(), 3);
    if (drain_q.size() == 3) begin
      chk("drain_0", drain_q[0], 1);
      chk("drain_1", drain_q[1], 2);
      chk("drain_2", drain_q[2], 4);
    end

    // x0 filtering on both sides.
    set_mdu(1, 5'd9, 64'h99);
    tick();
    set_mdu(0, 5'd0, 64'h0);
    set_wb(1, 1, 5'd0, 64'h55);
    eval();
    chk("x0_pipe_src", rf_src, 1);
    chk("x0_pipe_addr", rf_waddr, 9);
    chk("x0_pipe_stall", stall_pipe, 0);
    adv();
    eval();
    chk("x0_pipe_wen", rf_wen, 0);
    adv();
    set_wb(0, 0, 5'd0, 64'h0);
    set_mdu(1, 5'd0, 64'hEE);
    eval();
    chk("x0_mdu_ready", mdu_ready, 1);
    adv();
    set_mdu(0, 5'd0, 64'h0);
    eval();
    chk("x0_mdu_count", fifo_count, 0);
    adv();

    // Reset mid-operation: two entries queued, age at 3.
    set_wb(1, 1, 5'd3, 64'h33);
    set_mdu(1, 5'd10, 64'hA0);
    tick();
    set_mdu(1, 5'd11, 64'hB0);
    tick();
    set_mdu(0, 5'd0, 64'h0);
    tick();
    tick();
    reset = 1'b1;
    eval();
    chk("midrst_count", fifo_count, 0);
    chk("midrst_mask", pending_mask, 0);
    adv();
    reset = 1'b0;
    set_wb(0, 0, 5'd0, 64'h0);
    repeat (4) begin
      eval();
      chk("midrst_no_stale", rf_wen, 0);
      adv();
    end

    // Randomized traffic obeying both hold rules.
    for (int n = 0; n < 2000; n++) begin
      bit hold_mdu, hold_wb;
      eval();
      hold_mdu = mdu_valid && !mdu_ready && !reset;
      hold_wb  = stall_pipe === 1'b1;
      adv();
      reset = ($urandom_range(0, 199) == 0);
      if (!hold_wb) begin
        set_wb($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               {$urandom, $urandom});
      end
      if (!hold_mdu) begin
        set_mdu($urandom_range(0, 2) == 0,
                ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                {$urandom, $urandom});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
